mesh_router_input: RTL

//  One input port of the mesh router. Accepts 64-bit packets from the neighbouring
//  NIC or router over the si/ri/di handshake and stores them in two one-entry

---
 rtl/mesh_router_input_if.sv | 12 +
 rtl/mesh_router_input.sv | 90 +++++++++
 2 files changed

// File: rtl/mesh_router_input_if.sv
// mesh_router_input_if: upstream si/ri/di handshake plus request/grant/data toward the output arbiter
interface mesh_router_input_if #(parameter int PKT_W = 64);
  logic             in_si;
  logic             in_ri;
  logic [PKT_W-1:0] in_di;
  logic [2:0]       out_req;
  logic             out_dir;
  logic             out_gnt;
  logic [PKT_W-1:0] out_do;
  modport master (output in_si, in_di, out_gnt, input in_ri, out_req, out_dir, out_do);
  modport slave (input in_si, in_di, out_gnt, output in_ri, out_req, out_dir, out_do);
endinterface

// File: rtl/mesh_router_input.sv
// mesh_router_input: mesh router input port with two polarity-selected VC buffers and XY routing; MESH_RIN_STATS_EN adds stat counters
module mesh_router_input #(
  parameter int PKT_W  = 64,
  parameter int HOP_W  = 4,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              polarity,
`ifdef MESH_RIN_STATS_EN
  output logic [STAT_W-1:0] stat_pkts,
  output logic [STAT_W-1:0] stat_drop,
  output logic [STAT_W-1:0] stat_stall,
`endif
  mesh_router_input_if.slave bus
);
  localparam int HX = PKT_W - 9;
  localparam int HY = HX - HOP_W;
  typedef enum logic {EMPTY, HELD} vc_state_e;
  vc_state_e        state [2];
  vc_state_e        state_nxt [2];
  logic [PKT_W-1:0] pkt [2];
  logic [2:0]       route [2];
  logic             dir [2];
  logic             wvc, rvc, ri, held, accept, grant;
  logic [HOP_W-1:0] hx, hy;
  logic [2:0]       req_in;
  logic             dir_in;
  logic [PKT_W-1:0] pkt_in;
  assign wvc    = ~polarity;
  assign rvc    = polarity;
  assign ri     = state[wvc] == EMPTY;
  assign held   = state[rvc] == HELD;
  assign accept = bus.in_si && ri;
  assign grant  = bus.out_gnt && held;
  assign hx     = bus.in_di[HX -: HOP_W];
  assign hy     = bus.in_di[HY -: HOP_W];
  assign bus.in_ri   = ri;
  assign bus.out_req = held ? route[rvc] : 3'b000;
  assign bus.out_dir = held ? dir[rvc] : 1'b0;
  assign bus.out_do  = held ? pkt[rvc] : '0;
  // X-then-Y route of the incoming packet; the hop count of the chosen dimension is decremented, a zero count never is
  always_comb begin
    pkt_in = bus.in_di;
    req_in = hx != '0 ? 3'b100 : hy != '0 ? 3'b010 : 3'b001;
    dir_in = hx != '0 ? bus.in_di[PKT_W-2] : hy != '0 ? bus.in_di[PKT_W-3] : 1'b0;
    if (hx != '0) pkt_in[HX -: HOP_W] = hx - 1'b1;
    else if (hy != '0) pkt_in[HY -: HOP_W] = hy - 1'b1;
  end
  // per-VC next state: the write VC fills on accept, the read VC drains on grant; they are never the same VC
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_nxt[i] = state[i];
      if (accept && wvc == 1'(i)) state_nxt[i] = HELD;
      if (grant && rvc == 1'(i)) state_nxt[i] = EMPTY;
    end
  end
  // VC state, buffer and registered route; the packet is stored already route-updated
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        state[i] <= EMPTY;
        pkt[i]   <= '0;
        route[i] <= 3'b000;
        dir[i]   <= 1'b0;
      end else begin
        state[i] <= state_nxt[i];
        if (accept && wvc == 1'(i)) begin
          pkt[i]   <= pkt_in;
          route[i] <= req_in;
          dir[i]   <= dir_in;
        end
      end
    end
  end
`ifdef MESH_RIN_STATS_EN
  // saturating accept / drop / stall counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_pkts  <= '0;
      stat_drop  <= '0;
      stat_stall <= '0;
    end else begin
      if (accept && ~&stat_pkts) stat_pkts <= stat_pkts + 1'b1;
      if (bus.in_si && !ri && ~&stat_drop) stat_drop <= stat_drop + 1'b1;
      if (held && !bus.out_gnt && ~&stat_stall) stat_stall <= stat_stall + 1'b1;
    end
  end
`endif
endmodule
